mac_array_ctrl: RTL and testbench

Sequencer for the 2D MAC array built from stacked `mac_row` instances. On a `start` pulse it runs one kernel-load phase, then one execute phase of `num_x` input vectors. It pops the L0 input buffer, generates the row-skewed `inst_w` bus for every row, and holds `mode_select` stable for the whole operation. It pushes each completed column-result vector into the output FIFO and signals `done` when all results have left the array.

---
 rtl/mac_array_ctrl.sv | 121 ++++++++++++
 tb/tb_mac_array_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequencer for the stacked mac_row array.
// Runs one kernel-load phase followed by one execute phase per start,
// skews the issued op down the rows and counts results leaving the array.
module mac_array_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode_in,
  input  logic [cnt_bw-1:0]   num_x,
  input  logic                l0_empty,
  output logic                l0_rd,
  output logic [2*row-1:0]    inst_w,
  output logic                mode_select,
  input  logic [col-1:0]      array_valid,
  input  logic                ofifo_afull,
  output logic                ofifo_wr,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_KGAP  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Bubble cycles needed for the load wavefront to leave the bottom-right tile.
  localparam int GAP = row + col - 1;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [cnt_bw-1:0] ld_cnt;
  logic [cnt_bw-1:0] gap_cnt;
  logic [cnt_bw-1:0] ex_cnt;
  logic [cnt_bw-1:0] out_cnt;
  logic [cnt_bw-1:0] num_x_q;
  logic              mode_q;
  logic              issue_ld;
  logic              issue_ex;
  logic              drain_ok;
  logic [1:0]        skew_p [row];

  // Issue decisions use this cycle's buffer flags directly, so a stall costs no extra bubble.
  always_comb begin
    issue_ld = (state == S_LOAD) && !l0_empty;
    issue_ex = (state == S_EXEC) && !l0_empty && !ofifo_afull;
    l0_rd    = issue_ld || issue_ex;
    ofifo_wr = &array_valid;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    mode_select = mode_q;
    // A push in this very cycle may complete the run, so count it before it lands in out_cnt.
    drain_ok = (out_cnt == num_x_q) ||
               (ofifo_wr && ((out_cnt + cnt_bw'(1)) == num_x_q));
  end

  // Phase sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (issue_ld && (ld_cnt == cnt_bw'(col - 1))) state_nxt = S_KGAP;
      S_KGAP:  if (gap_cnt == cnt_bw'(GAP - 1))
                 state_nxt = (num_x_q == '0) ? S_DRAIN : S_EXEC;
      S_EXEC:  if (issue_ex && (ex_cnt == (num_x_q - cnt_bw'(1)))) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_ok) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, run parameters and phase counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      ld_cnt  <= '0;
      gap_cnt <= '0;
      ex_cnt  <= '0;
      out_cnt <= '0;
      num_x_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && start) begin
        ld_cnt  <= '0;
        gap_cnt <= '0;
        ex_cnt  <= '0;
        out_cnt <= '0;
        num_x_q <= num_x;
        mode_q  <= mode_in;
      end else begin
        if (issue_ld)          ld_cnt  <= ld_cnt + cnt_bw'(1);
        if (state == S_KGAP)   gap_cnt <= gap_cnt + cnt_bw'(1);
        if (issue_ex)          ex_cnt  <= ex_cnt + cnt_bw'(1);
        if (ofifo_wr)          out_cnt <= out_cnt + cnt_bw'(1);
      end
    end
  end

  // Row skew: row 0 takes the issued op, each lower row sees the one above a cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < row; r++) skew_p[r] <= 2'b00;
    end else begin
      skew_p[0] <= {issue_ex, issue_ld};
      for (int r = 1; r < row; r++) skew_p[r] <= skew_p[r-1];
    end
  end

  // Flatten the skew stages onto the per-row instruction bus.
  always_comb begin
    inst_w = '0;
    for (int r = 0; r < row; r++) inst_w[2*r +: 2] = skew_p[r];
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Testbench for mac_array_ctrl: randomized flag patterns checked against an
// issue-list model of the load/gap/execute/drain schedule.
module tb_mac_array_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int CBW  = 8;
  localparam int MAXC = 512;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mode_in;
  logic [CBW-1:0]   num_x;
  logic             l0_empty;
  logic             l0_rd;
  logic [2*ROW-1:0] inst_w;
  logic             mode_select;
  logic [COL-1:0]   array_valid;
  logic             ofifo_afull;
  logic             ofifo_wr;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;
  bit emp [MAXC];
  bit afl [MAXC];
  bit bot_prev;

  always #5 clk = ~clk;

  mac_array_ctrl #(.row(ROW), .col(COL), .cnt_bw(CBW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .num_x(num_x),
    .l0_empty(l0_empty), .l0_rd(l0_rd), .inst_w(inst_w), .mode_select(mode_select),
    .array_valid(array_valid), .ofifo_afull(ofifo_afull), .ofifo_wr(ofifo_wr),
    .busy(busy), .done(done)
  );

  // Partial valid vector that never has every column set.
  function automatic logic [COL-1:0] noise();
    logic [COL-1:0] v;
    v = COL'($urandom);
    v[$urandom_range(COL-1, 0)] = 1'b0;
    return v;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      emp[i] = 1'b0;
      afl[i] = 1'b0;
    end
  endtask

  // One full run: model builds the schedule of issues, then the DUT is checked every cycle.
  task automatic run_scenario(input string name, input int n, input bit mode, input int restart_cyc);
    int iss [MAXC];
    bit pushc [MAXC];
    int t, ld, ex, last_push, done_c, pushes, idx;
    logic [2*ROW-1:0] exp_inst;
    for (int i = 0; i < MAXC; i++) begin
      iss[i] = 0;
      pushc[i] = 1'b0;
    end
    // Loads go out on the first COL cycles with data available.
    t = 1; ld = 0;
    while (ld < COL && t < MAXC - 64) begin
      if (!emp[t]) begin iss[t] = 1; ld++; end
      t++;
    end
    // Fixed gap, then executes on cycles with data and output room.
    t = t + ROW + COL - 1;
    ex = 0; last_push = 0;
    while (ex < n && t < MAXC - 64) begin
      if (!emp[t] && !afl[t]) begin
        iss[t] = 2;
        ex++;
        last_push = t + ROW + 1;
        pushc[last_push] = 1'b1;
      end
      t++;
    end
    done_c = ((t > last_push) ? t : last_push) + 1;
    if (done_c + 3 >= MAXC || ld < COL || ex < n) begin
      n_cmp++; n_err++;
      $display("FAIL %s schedule does not fit bench window (done_c=%0d)", name, done_c);
      return;
    end

    #1;
    mode_in = mode; num_x = CBW'(n); start = 1'b1;
    l0_empty = 1'b0; ofifo_afull = 1'b0; array_valid = noise();
    @(posedge clk);
    bot_prev = 1'b0; pushes = 0;
    for (int c = 1; c <= done_c + 2; c++) begin
      #1;
      start       = (c == restart_cyc);
      mode_in     = (c == restart_cyc) ? ~mode : mode;
      l0_empty    = emp[c];
      ofifo_afull = afl[c];
      array_valid = bot_prev ? {COL{1'b1}} : noise();
      #1;
      exp_inst = '0;
      for (int r = 0; r < ROW; r++) begin
        idx = c - 1 - r;
        if (idx >= 1) exp_inst[2*r +: 2] = 2'(iss[idx]);
      end
      n_cmp++;
      if (l0_rd !== (iss[c] != 0)) begin
        n_err++;
        $display("FAIL %s l0_rd cyc%0d got %b want %b", name, c, l0_rd, (iss[c] != 0));
      end
      n_cmp++;
      if (inst_w !== exp_inst) begin
        n_err++;
        $display("FAIL %s inst_w cyc%0d got %h want %h", name, c, inst_w, exp_inst);
      end
      n_cmp++;
      if (busy !== (c <= done_c)) begin
        n_err++;
        $display("FAIL %s busy cyc%0d got %b want %b", name, c, busy, (c <= done_c));
      end
      n_cmp++;
      if (done !== (c == done_c)) begin
        n_err++;
        $display("FAIL %s done cyc%0d got %b want %b", name, c, done, (c == done_c));
      end
      n_cmp++;
      if (mode_select !== mode) begin
        n_err++;
        $display("FAIL %s mode_select cyc%0d got %b want %b", name, c, mode_select, mode);
      end
      n_cmp++;
      if (ofifo_wr !== pushc[c]) begin
        n_err++;
        $display("FAIL %s ofifo_wr cyc%0d got %b want %b", name, c, ofifo_wr, pushc[c]);
      end
      if (ofifo_wr === 1'b1) pushes++;
      bot_prev = inst_w[2*ROW-1];
      @(posedge clk);
    end
    n_cmp++;
    if (pushes != n) begin
      n_err++;
      $display("FAIL %s push_count got %0d want %0d", name, pushes, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; mode_in = 1'b1; num_x = 8'd5;
    l0_empty = 1'b0; ofifo_afull = 1'b0; array_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || l0_rd !== 1'b0 || inst_w !== '0 || mode_select !== 1'b0) begin
        n_err++;
        $display("FAIL reset outputs got busy=%b done=%b rd=%b inst=%h mode=%b want all 0",
                 busy, done, l0_rd, inst_w, mode_select);
      end
    end
    start = 1'b0; reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_nominal();
    clear_stim();
    run_scenario("nominal", 4, 1'b0, -1);
  endtask

  task automatic test_l0_underflow();
    clear_stim();
    for (int i = 4; i <= 6; i++) emp[i] = 1'b1;
    emp[28] = 1'b1; emp[29] = 1'b1;
    run_scenario("underflow", 4, 1'b1, -1);
  endtask

  task automatic test_backpressure();
    clear_stim();
    for (int i = 30; i <= 35; i++) afl[i] = 1'b1;
    run_scenario("backpressure", 12, 1'b0, -1);
  endtask

  task automatic test_load_only();
    clear_stim();
    run_scenario("load_only", 0, 1'b1, 12);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++) begin
      clear_stim();
      for (int i = 1; i < MAXC; i++) begin
        emp[i] = ($urandom_range(3, 0) == 0);
        afl[i] = ($urandom_range(3, 0) == 0);
      end
      run_scenario("random", $urandom_range(20, 1), 1'($urandom), -1);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    run_scenario("b2b_a", 3, 1'b1, -1);
    run_scenario("b2b_b", 5, 1'b0, -1);
  endtask

  task automatic test_reset_mid_exec();
    clear_stim();
    #1;
    mode_in = 1'b1; num_x = 8'd10; start = 1'b1;
    l0_empty = 1'b0; ofifo_afull = 1'b0; array_valid = noise();
    @(posedge clk);
    for (int c = 1; c <= 26; c++) begin
      #1;
      start = 1'b0;
      array_valid = noise();
      if (c == 26) reset = 1'b0;
      @(posedge clk);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (inst_w !== '0 || busy !== 1'b0 || done !== 1'b0 || l0_rd !== 1'b0 || mode_select !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset outputs got inst=%h busy=%b done=%b rd=%b mode=%b want all 0",
               inst_w, busy, done, l0_rd, mode_select);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #2;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_idle cyc%0d got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    clear_stim();
    run_scenario("after_reset", 4, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_l0_underflow();
    test_backpressure();
    test_load_only();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
